// File: rtl/video_mnist_cnn_pooling_pkg.sv
// Shared definitions for the binary MNIST CNN pooling stage.
//   POOL_MIN / POOL_MAX : legal range of the pooling factors
//   PHASE_W / KIND_W    : field widths of the stage-1 record (px/py phase, row kind)
//   row_kind_e          : what stage 2 does with a closed group
//   clamp_pool, ceil_div, addr_width : elaboration-time helpers
package video_mnist_cnn_pooling_pkg;

    localparam int unsigned POOL_MIN = 1;
    localparam int unsigned POOL_MAX = 8;

    // Phase counters hold 0..POOL_MAX-1.
    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned KIND_W   = 2;

    // ROW_FIRST : write group to the line buffer
    // ROW_MID   : OR group into the line buffer
    // ROW_LAST  : emit group OR line buffer, no write
    // ROW_PASS  : emit group as is (bypass, or POOL_Y == 1)
    typedef enum logic [KIND_W-1:0] {
        ROW_FIRST,
        ROW_MID,
        ROW_LAST,
        ROW_PASS
    } row_kind_e;

    function automatic int unsigned clamp_pool(input int unsigned f);
        if (f < POOL_MIN) return POOL_MIN;
        if (f > POOL_MAX) return POOL_MAX;
        return f;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/video_mnist_cnn_pooling_linebuf.sv
// Line buffer holding one partially pooled value per column group.
//   clk     : clock
//   we      : write enable, wr_addr / wr_data : write port
//   rd_en   : read enable (holds rd_data when low), rd_addr : read address
//   rd_data : read data, valid one cycle after rd_addr is sampled
// RAM_TYPE "block" registers the data; any other value registers the
// address and reads asynchronously (distributed RAM style). Both give
// one cycle of read latency.
module video_mnist_cnn_pooling_linebuf #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 16,
    parameter string       RAM_TYPE = "block"
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (RAM_TYPE == "block") begin : g_block
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_dist
            logic [ADDR_W-1:0] addr_q;
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    addr_q <= rd_addr;
                end
            end
            assign rd_data = mem[addr_q];
        end
    endgenerate

endmodule

// File: rtl/video_mnist_cnn_pooling.sv
// Binary max pooling (bitwise OR) over POOL_X x POOL_Y blocks of an
// AXI4-Stream video frame.
//   clk, reset         : single clock, synchronous active-high reset
//   param_bypass       : latched at frame start; frame passes 1:1 when set
//   s_axi4s_*          : input stream (tuser[0] = frame start, tlast = line end)
//   m_axi4s_*          : pooled output stream
// Pipeline: stage 1 accepts a beat, builds the group and issues the line
// buffer read; stage 2 combines with the buffer and loads the output
// register. The whole pipe advances on cke = !m_tvalid || m_tready.
module video_mnist_cnn_pooling
    import video_mnist_cnn_pooling_pkg::*;
#(
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TDATA_WIDTH = 16,
    parameter int unsigned POOL_X      = 2,
    parameter int unsigned POOL_Y      = 2,
    parameter int unsigned MAX_X_NUM   = 1024,
    parameter int unsigned IMG_X_WIDTH = 11,
    parameter string       RAM_TYPE    = "block"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   param_bypass,
    input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
    input  logic                   s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                   s_axi4s_tvalid,
    output logic                   s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
    output logic                   m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                   m_axi4s_tvalid,
    input  logic                   m_axi4s_tready
);

    localparam int unsigned POOL_X_C  = clamp_pool(POOL_X);
    localparam int unsigned POOL_Y_C  = clamp_pool(POOL_Y);
    localparam int unsigned BUF_DEPTH = ceil_div(MAX_X_NUM, POOL_X_C);
    localparam int unsigned ADDR_W    = addr_width(BUF_DEPTH);

    localparam logic [PHASE_W-1:0] PX_LAST = PHASE_W'(POOL_X_C - 1);
    localparam logic [PHASE_W-1:0] PY_LAST = PHASE_W'(POOL_Y_C - 1);

    logic cke;

    // Frame / position state
    logic                   bypass_q;
    logic                   active_q;
    logic                   first_q;
    logic [PHASE_W-1:0]     px_q;
    logic [PHASE_W-1:0]     py_q;
    logic [IMG_X_WIDTH-1:0] gx_q;
    logic [TDATA_WIDTH-1:0] acc_q;
    logic [TUSER_WIDTH-1:0] gusr_q;

    // Stage-1 combinational view of the incoming beat
    logic                   sof;
    logic                   accept;
    logic                   byp;
    logic                   first_cur;
    logic [PHASE_W-1:0]     px_cur;
    logic [PHASE_W-1:0]     py_cur;
    logic [IMG_X_WIDTH-1:0] gx_cur;
    logic [TDATA_WIDTH-1:0] grp_data;
    logic [TUSER_WIDTH-1:0] grp_user;
    logic [TUSER_WIDTH-1:0] out_user;
    logic                   close;
    logic                   emits;
    row_kind_e              kind;
    logic [ADDR_W-1:0]      rd_addr;

    // Stage-1 record
    logic                   s1_valid;
    row_kind_e              s1_kind;
    logic [ADDR_W-1:0]      s1_addr;
    logic [TDATA_WIDTH-1:0] s1_data;
    logic                   s1_last;
    logic [TUSER_WIDTH-1:0] s1_user;

    // Stage 2
    logic                   fwd_q;
    logic [TDATA_WIDTH-1:0] fwd_data_q;
    logic [TDATA_WIDTH-1:0] rd_data;
    logic [TDATA_WIDTH-1:0] buf_val;
    logic [TDATA_WIDTH-1:0] s2_data;
    logic                   s2_emit;
    logic                   s2_we;

    assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
    assign s_axi4s_tready = cke;

    // A frame start restarts all position state in the same beat, so the
    // "current" phase/group values are muxed before use.
    always_comb begin
        sof       = s_axi4s_tuser[0];
        accept    = cke && s_axi4s_tvalid && (sof || active_q);
        byp       = sof ? param_bypass : bypass_q;
        px_cur    = sof ? '0 : px_q;
        gx_cur    = sof ? '0 : gx_q;
        py_cur    = sof ? '0 : py_q;
        first_cur = sof || first_q;
        grp_data  = (px_cur == '0) ? s_axi4s_tdata : (acc_q | s_axi4s_tdata);
        grp_user  = (px_cur == '0) ? s_axi4s_tuser : gusr_q;
        close     = byp || s_axi4s_tlast || (px_cur == PX_LAST);

        if (byp) begin
            kind = ROW_PASS;
        end else if (py_cur == PY_LAST) begin
            kind = (PY_LAST == '0) ? ROW_PASS : ROW_LAST;
        end else if (py_cur == '0) begin
            kind = ROW_FIRST;
        end else begin
            kind = ROW_MID;
        end
        emits = (kind == ROW_PASS) || (kind == ROW_LAST);

        out_user    = grp_user;
        out_user[0] = first_cur;
        if (byp) begin
            out_user = s_axi4s_tuser;
        end

        rd_addr = ADDR_W'(gx_cur);
    end

    // Stage 1: position tracking, group accumulation, read issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            bypass_q   <= 1'b0;
            active_q   <= 1'b0;
            first_q    <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            gx_q       <= '0;
            acc_q      <= '0;
            gusr_q     <= '0;
            s1_valid   <= 1'b0;
            s1_kind    <= ROW_FIRST;
            s1_addr    <= '0;
            s1_data    <= '0;
            s1_last    <= 1'b0;
            s1_user    <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else if (cke) begin
            s1_valid   <= accept && close;
            // The buffer read issued now misses the write landing on this
            // same edge; remember that write so stage 2 can use it instead.
            fwd_q      <= s2_we && (s1_addr == rd_addr);
            fwd_data_q <= s2_data;
            if (accept) begin
                if (sof) begin
                    bypass_q <= param_bypass;
                    active_q <= 1'b1;
                end
                first_q <= first_cur && !(close && emits);
                acc_q   <= grp_data;
                gusr_q  <= grp_user;
                if (close) begin
                    s1_kind <= kind;
                    s1_addr <= rd_addr;
                    s1_data <= grp_data;
                    s1_last <= s_axi4s_tlast;
                    s1_user <= out_user;
                end
                if (s_axi4s_tlast) begin
                    px_q <= '0;
                    gx_q <= '0;
                    py_q <= (py_cur == PY_LAST) ? '0 : py_cur + PHASE_W'(1);
                end else if (close) begin
                    px_q <= '0;
                    gx_q <= gx_cur + IMG_X_WIDTH'(1);
                    py_q <= py_cur;
                end else begin
                    px_q <= px_cur + PHASE_W'(1);
                    gx_q <= gx_cur;
                    py_q <= py_cur;
                end
            end
        end
    end

    always_comb begin
        buf_val = fwd_q ? fwd_data_q : rd_data;
        if (s1_kind == ROW_FIRST || s1_kind == ROW_PASS) begin
            s2_data = s1_data;
        end else begin
            s2_data = s1_data | buf_val;
        end
        s2_emit = s1_valid && (s1_kind == ROW_LAST || s1_kind == ROW_PASS);
        s2_we   = cke && s1_valid && (s1_kind == ROW_FIRST || s1_kind == ROW_MID);
    end

    // Stage 2: output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tlast  <= 1'b0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tdata  <= '0;
        end else if (cke) begin
            m_axi4s_tvalid <= s2_emit;
            if (s2_emit) begin
                m_axi4s_tlast <= s1_last;
                m_axi4s_tuser <= s1_user;
                m_axi4s_tdata <= s2_data;
            end
        end
    end

    video_mnist_cnn_pooling_linebuf #(
        .DEPTH   (BUF_DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (TDATA_WIDTH),
        .RAM_TYPE(RAM_TYPE)
    ) u_linebuf (
        .clk    (clk),
        .we     (s2_we),
        .wr_addr(s1_addr),
        .wr_data(s2_data),
        .rd_en  (cke),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_video_mnist_cnn_pooling.sv
// Self-checking bench for video_mnist_cnn_pooling.
// DUT A: 2x2 pooling, default sizes. DUT B: POOL_X=2, POOL_Y=4, small buffer.
// Output beats are packed as {tuser, tlast, tdata} (18 bits).
module tb_video_mnist_cnn_pooling;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A
    logic        a_bypass;
    logic [0:0]  a_suser;
    logic        a_slast;
    logic [15:0] a_sdata;
    logic        a_svalid;
    logic        a_sready;
    logic [0:0]  a_muser;
    logic        a_mlast;
    logic [15:0] a_mdata;
    logic        a_mvalid;
    logic        a_mready;

    // DUT B
    logic [0:0]  b_suser;
    logic        b_slast;
    logic [15:0] b_sdata;
    logic        b_svalid;
    logic        b_sready;
    logic [0:0]  b_muser;
    logic        b_mlast;
    logic [15:0] b_mdata;
    logic        b_mvalid;
    logic        b_mready;

    video_mnist_cnn_pooling #(
        .POOL_X(2),
        .POOL_Y(2)
    ) u_dut_a (
        .clk           (clk),
        .reset         (rst),
        .param_bypass  (a_bypass),
        .s_axi4s_tuser (a_suser),
        .s_axi4s_tlast (a_slast),
        .s_axi4s_tdata (a_sdata),
        .s_axi4s_tvalid(a_svalid),
        .s_axi4s_tready(a_sready),
        .m_axi4s_tuser (a_muser),
        .m_axi4s_tlast (a_mlast),
        .m_axi4s_tdata (a_mdata),
        .m_axi4s_tvalid(a_mvalid),
        .m_axi4s_tready(a_mready)
    );

    video_mnist_cnn_pooling #(
        .POOL_X     (2),
        .POOL_Y     (4),
        .MAX_X_NUM  (8),
        .IMG_X_WIDTH(4)
    ) u_dut_b (
        .clk           (clk),
        .reset         (rst),
        .param_bypass  (1'b0),
        .s_axi4s_tuser (b_suser),
        .s_axi4s_tlast (b_slast),
        .s_axi4s_tdata (b_sdata),
        .s_axi4s_tvalid(b_svalid),
        .s_axi4s_tready(b_sready),
        .m_axi4s_tuser (b_muser),
        .m_axi4s_tlast (b_mlast),
        .m_axi4s_tdata (b_mdata),
        .m_axi4s_tvalid(b_mvalid),
        .m_axi4s_tready(b_mready)
    );

    int unsigned n_tests  = 0;
    int unsigned n_fail   = 0;
    int unsigned hold_err = 0;
    int          ready_mode = 0;   // 0: always ready, 1: 30% random, 2: never

    logic [15:0] img [8][64];
    logic [17:0] out_a [$];
    logic [17:0] out_b [$];
    logic [17:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready for DUT A, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       a_mready = ($urandom_range(0, 99) < 30);
            2:       a_mready = 1'b0;
            default: a_mready = 1'b1;
        endcase
    end

    // Output capture and hold-while-stalled monitoring, away from the edge.
    logic        prev_stall = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!a_mvalid || {a_muser, a_mlast, a_mdata} !== held))
                hold_err++;
            prev_stall = a_mvalid && !a_mready;
            held       = {a_muser, a_mlast, a_mdata};
            if (a_mvalid && a_mready) out_a.push_back({a_muser, a_mlast, a_mdata});
            if (b_mvalid && b_mready) out_b.push_back({b_muser, b_mlast, b_mdata});
        end
    end

    // All drive tasks start and end at posedge + 1.
    task automatic send_a(input logic [15:0] d, input logic u, input logic l);
        int   guard = 0;
        logic ok;
        a_sdata  = d;
        a_suser  = u;
        a_slast  = l;
        a_svalid = 1'b1;
        do begin
            @(negedge clk);
            ok = a_sready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 1000);
        if (!ok) check("send_a_ready", ok, 1);
        a_svalid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic u, input logic l);
        int   guard = 0;
        logic ok;
        b_sdata  = d;
        b_suser  = u;
        b_slast  = l;
        b_svalid = 1'b1;
        do begin
            @(negedge clk);
            ok = b_sready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 1000);
        if (!ok) check("send_b_ready", ok, 1);
        b_svalid = 1'b0;
    endtask

    task automatic send_img_a(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                send_a(img[y][x], (x == 0 && y == 0), (x == w - 1));
    endtask

    task automatic fill_sparse(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                img[y][x] = 16'($urandom) & 16'($urandom) & 16'($urandom);
    endtask

    // Reference 2x2 OR pooling straight from the image array.
    task automatic build_expect(input int w, input int h);
        int          ow;
        logic [15:0] v;
        exp_q.delete();
        ow = (w + 1) / 2;
        for (int oy = 0; oy < h / 2; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                v = '0;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (2 * ox + dx < w) v = v | img[2 * oy + dy][2 * ox + dx];
                exp_q.push_back({(ox == 0 && oy == 0), (ox == ow - 1), v});
            end
        end
    endtask

    task automatic compare_a(input string name);
        int guard = 0;
        while (out_a.size() < exp_q.size() && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        repeat (8) @(posedge clk);
        #1;
        check({name, "_count"}, out_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_a.size(); i++)
            check($sformatf("%s[%0d]", name, i), out_a[i], exp_q[i]);
        out_a.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        u;
        logic        l;

        rst      = 1'b1;
        a_bypass = 1'b0;
        a_suser  = '0;
        a_slast  = 1'b0;
        a_sdata  = '0;
        a_svalid = 1'b0;
        a_mready = 1'b1;
        b_suser  = '0;
        b_slast  = 1'b0;
        b_sdata  = '0;
        b_svalid = 1'b0;
        b_mready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mvalid", a_mvalid, 0);
        check("rst_sready", a_sready, 1);
        check("rst_mdata",  a_mdata,  0);
        check("rst_mlast",  a_mlast,  0);
        check("rst_muser",  a_muser,  0);
        check("rst_b_mvalid", b_mvalid, 0);
        @(posedge clk);
        #1;

        // 4x4 frame, single set pixel at row 1 / column 2
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                img[y][x] = '0;
        img[1][2] = 16'h0008;
        send_img_a(4, 4);
        exp_q.delete();
        exp_q.push_back(18'h20000);
        exp_q.push_back(18'h10008);
        exp_q.push_back(18'h00000);
        exp_q.push_back(18'h10000);
        compare_a("onehot4x4");

        // 5-pixel lines: last group holds one pixel per row
        for (int x = 0; x < 5; x++) begin
            img[0][x] = 16'(1 << x);
            img[1][x] = 16'(1 << (x + 5));
        end
        send_img_a(5, 2);
        exp_q.delete();
        exp_q.push_back(18'h20063);
        exp_q.push_back(18'h0018C);
        exp_q.push_back(18'h10210);
        compare_a("line5");

        // 64x8 frame with 30% downstream ready
        ready_mode = 1;
        fill_sparse(64, 8);
        build_expect(64, 8);
        send_img_a(64, 8);
        compare_a("stall64x8");
        ready_mode = 0;
        check("stall_hold", hold_err, 0);

        // DUT B: 1-pixel-wide frame, 8 rows, POOL_Y = 4
        for (int y = 0; y < 8; y++)
            send_b(16'(1 << y), (y == 0), 1'b1);
        begin
            int guard = 0;
            while (out_b.size() < 2 && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            repeat (6) @(posedge clk);
            #1;
        end
        check("col1_count", out_b.size(), 2);
        if (out_b.size() >= 2) begin
            check("col1[0]", out_b[0], 18'h3000F);
            check("col1[1]", out_b[1], 18'h100F0);
        end

        // Bypass latched at frame start, toggle mid-frame ignored
        exp_q.delete();
        a_bypass = 1'b1;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (y == 0 && x == 2) a_bypass = 1'b0;
                d = 16'($urandom);
                u = (x == 0 && y == 0);
                l = (x == 3);
                send_a(d, u, l);
                exp_q.push_back({u, l, d});
            end
        end
        compare_a("bypass");

        // Next frame pools again; a mid-frame bypass request is ignored
        fill_sparse(4, 2);
        build_expect(4, 2);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                if (y == 0 && x == 2) a_bypass = 1'b1;
                send_a(img[y][x], (x == 0 && y == 0), (x == 3));
            end
        a_bypass = 1'b0;
        compare_a("bypass_off");

        // Reset pulsed mid-row with an output held by backpressure
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int x = 0; x < 4; x++) send_a(16'h0001, (x == 0), (x == 3));
        send_a(16'h0002, 1'b0, 1'b0);
        send_a(16'h0004, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_mvalid", a_mvalid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_mvalid", a_mvalid, 0);
        @(posedge clk);
        #1;
        ready_mode = 0;
        out_a.delete();
        // Stray beats without frame start must not produce output
        send_a(16'hFFFF, 1'b0, 1'b0);
        send_a(16'hFFFF, 1'b0, 1'b1);
        fill_sparse(4, 4);
        build_expect(4, 4);
        send_img_a(4, 4);
        compare_a("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
